// File: rtl/t80_mem_arb.sv
// Round-robin arbiter sharing one synchronous single-port RAM between the T80 core
// and the synchronized host backdoor; one registered RAM cycle at a time.
module t80_mem_arb #(
    parameter int unsigned ASZ   = 11,
    parameter int unsigned DEPTH = 2048
) (
    input  logic           clk250,
    input  logic           reset,
    input  logic           mem_req,
    input  logic           mem_rd,
    input  logic [ASZ-1:0] addr,
    input  logic [7:0]     mem_wdata,
    output logic           mem_ack,
    output logic [7:0]     mem_rdata,
    input  logic           cpu_t80_mem_req,
    input  logic           cpu_t80_mem_read,
    input  logic [ASZ-1:0] cpu_t80_addr,
    input  logic [7:0]     cpu_t80_mem_wdata,
    output logic           t80_cpu_mem_ack,
    output logic [7:0]     t80_cpu_mem_rdata,
    output logic           ram_cs,
    output logic           ram_we,
    output logic [ASZ-1:0] ram_addr,
    output logic [7:0]     ram_wdata,
    input  logic [7:0]     ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic           GNT_T80   = 1'b0;
    localparam logic           GNT_HOST  = 1'b1;
    localparam logic [ASZ-1:0] ADDR_MASK = ASZ'(DEPTH - 1);

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic           rd_q, rd_d;
    logic           ram_cs_q, ram_cs_d;
    logic           ram_we_q, ram_we_d;
    logic [ASZ-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]     ram_wdata_q, ram_wdata_d;
    logic           mem_ack_q, mem_ack_d;
    logic [7:0]     mem_rdata_q, mem_rdata_d;
    logic           host_ack_q, host_ack_d;
    logic [7:0]     host_rdata_q, host_rdata_d;

    logic t80_elig, host_elig, pick_host;

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rd_d         = rd_q;
        ram_cs_d     = ram_cs_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        mem_ack_d    = 1'b0;
        mem_rdata_d  = mem_rdata_q;
        host_ack_d   = host_ack_q;
        host_rdata_d = host_rdata_q;

        t80_elig  = mem_req && !mem_ack_q;
        host_elig = cpu_t80_mem_req && !host_ack_q;
        pick_host = host_elig && (!t80_elig || (last_grant_q == GNT_T80));

        // Host ack is a 4-phase level: it drops once the request is seen low
        if (host_ack_q && !cpu_t80_mem_req) begin
            host_ack_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (t80_elig || host_elig) begin
                    last_grant_d = pick_host ? GNT_HOST : GNT_T80;
                    rd_d         = pick_host ? cpu_t80_mem_read : mem_rd;
                    ram_cs_d     = 1'b1;
                    ram_we_d     = pick_host ? !cpu_t80_mem_read : !mem_rd;
                    ram_addr_d   = (pick_host ? cpu_t80_addr : addr) & ADDR_MASK;
                    ram_wdata_d  = pick_host ? cpu_t80_mem_wdata : mem_wdata;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                ram_cs_d = 1'b0;
                ram_we_d = 1'b0;
                state_d  = RESP;
            end
            RESP: begin
                if (last_grant_q == GNT_HOST) begin
                    if (rd_q) begin
                        host_rdata_d = ram_rdata;
                    end
                    host_ack_d = 1'b1;
                end else begin
                    if (rd_q) begin
                        mem_rdata_d = ram_rdata;
                    end
                    mem_ack_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                ram_cs_d = 1'b0;
                ram_we_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk250) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_HOST;
            rd_q         <= 1'b0;
            ram_cs_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            mem_ack_q    <= 1'b0;
            mem_rdata_q  <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rd_q         <= rd_d;
            ram_cs_q     <= ram_cs_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            mem_ack_q    <= mem_ack_d;
            mem_rdata_q  <= mem_rdata_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign mem_ack           = mem_ack_q;
    assign mem_rdata         = mem_rdata_q;
    assign t80_cpu_mem_ack   = host_ack_q;
    assign t80_cpu_mem_rdata = host_rdata_q;
    assign ram_cs            = ram_cs_q;
    assign ram_we            = ram_we_q;
    assign ram_addr          = ram_addr_q;
    assign ram_wdata         = ram_wdata_q;

endmodule

// File: tb/tb_t80_mem_arb.sv
// Directed bench for t80_mem_arb with a behavioural synchronous RAM attached.
module tb_t80_mem_arb;

    localparam int unsigned ASZ   = 11;
    localparam int unsigned DEPTH = 2048;

    logic           clk250 = 1'b0;
    logic           reset;
    logic           mem_req, mem_rd;
    logic [ASZ-1:0] addr;
    logic [7:0]     mem_wdata;
    logic           mem_ack;
    logic [7:0]     mem_rdata;
    logic           cpu_t80_mem_req, cpu_t80_mem_read;
    logic [ASZ-1:0] cpu_t80_addr;
    logic [7:0]     cpu_t80_mem_wdata;
    logic           t80_cpu_mem_ack;
    logic [7:0]     t80_cpu_mem_rdata;
    logic           ram_cs, ram_we;
    logic [ASZ-1:0] ram_addr;
    logic [7:0]     ram_wdata;
    logic [7:0]     ram_rdata;

    logic [7:0] ram [0:DEPTH-1];

    int checks   = 0;
    int failures = 0;

    t80_mem_arb #(.ASZ(ASZ), .DEPTH(DEPTH)) dut (
        .clk250            (clk250),
        .reset             (reset),
        .mem_req           (mem_req),
        .mem_rd            (mem_rd),
        .addr              (addr),
        .mem_wdata         (mem_wdata),
        .mem_ack           (mem_ack),
        .mem_rdata         (mem_rdata),
        .cpu_t80_mem_req   (cpu_t80_mem_req),
        .cpu_t80_mem_read  (cpu_t80_mem_read),
        .cpu_t80_addr      (cpu_t80_addr),
        .cpu_t80_mem_wdata (cpu_t80_mem_wdata),
        .t80_cpu_mem_ack   (t80_cpu_mem_ack),
        .t80_cpu_mem_rdata (t80_cpu_mem_rdata),
        .ram_cs            (ram_cs),
        .ram_we            (ram_we),
        .ram_addr          (ram_addr),
        .ram_wdata         (ram_wdata),
        .ram_rdata         (ram_rdata)
    );

    always #5 clk250 = ~clk250;

    // Synchronous RAM; reset reloads the one preloaded location
    always @(posedge clk250) begin
        if (reset) begin
            ram[11'h123] <= 8'hA5;
        end else if (ram_cs) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_rdata     <= ram[ram_addr];
        end
    end

    task automatic step();
        @(posedge clk250);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cs"},    32'(ram_cs), 32'd0);
        check({tag, "_we"},    32'(ram_we), 32'd0);
        check({tag, "_addr"},  32'(ram_addr), 32'd0);
        check({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
        check({tag, "_mack"},  32'(mem_ack), 32'd0);
        check({tag, "_mrd"},   32'(mem_rdata), 32'd0);
        check({tag, "_hack"},  32'(t80_cpu_mem_ack), 32'd0);
        check({tag, "_hrd"},   32'(t80_cpu_mem_rdata), 32'd0);
    endtask

    initial begin
        logic [11:0] addr12;
        int          cs_cnt;

        reset = 1'b1;
        mem_req = 1'b0; mem_rd = 1'b0; addr = '0; mem_wdata = '0;
        cpu_t80_mem_req = 1'b0; cpu_t80_mem_read = 1'b0;
        cpu_t80_addr = '0; cpu_t80_mem_wdata = '0;
        step(); step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // T80 read of preloaded 0x123
        mem_req = 1'b1; mem_rd = 1'b1; addr = 11'h123;
        step();
        check("t80rd_cs1",   32'(ram_cs), 32'd1);
        check("t80rd_we1",   32'(ram_we), 32'd0);
        check("t80rd_addr",  32'(ram_addr), 32'h123);
        check("t80rd_ack1",  32'(mem_ack), 32'd0);
        step();
        check("t80rd_cs2",   32'(ram_cs), 32'd0);
        check("t80rd_ack2",  32'(mem_ack), 32'd0);
        step();
        check("t80rd_ack3",  32'(mem_ack), 32'd1);
        check("t80rd_data",  32'(mem_rdata), 32'hA5);
        check("t80rd_cs3",   32'(ram_cs), 32'd0);
        mem_req = 1'b0;
        step();
        check("t80rd_ack4",  32'(mem_ack), 32'd0);

        // Host write 0x5A to 0x7FF, held request for 20 cycles after ack
        cpu_t80_mem_req = 1'b1; cpu_t80_mem_read = 1'b0;
        cpu_t80_addr = 11'h7FF; cpu_t80_mem_wdata = 8'h5A;
        step();
        check("hwr_cs",    32'(ram_cs), 32'd1);
        check("hwr_we",    32'(ram_we), 32'd1);
        check("hwr_addr",  32'(ram_addr), 32'h7FF);
        check("hwr_wdata", 32'(ram_wdata), 32'h5A);
        step(); step();
        check("hwr_ack",   32'(t80_cpu_mem_ack), 32'd1);
        cs_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ram_cs) cs_cnt++;
        end
        check("hwr_hold_cs",  32'(cs_cnt), 32'd0);
        check("hwr_hold_ack", 32'(t80_cpu_mem_ack), 32'd1);
        cpu_t80_mem_req = 1'b0;
        step();
        check("hwr_ack_clr",  32'(t80_cpu_mem_ack), 32'd0);

        // Host re-request: read back 0x7FF
        cpu_t80_mem_req = 1'b1; cpu_t80_mem_read = 1'b1;
        step();
        check("hrd_cs",   32'(ram_cs), 32'd1);
        step(); step();
        check("hrd_ack",  32'(t80_cpu_mem_ack), 32'd1);
        check("hrd_data", 32'(t80_cpu_mem_rdata), 32'h5A);
        cpu_t80_mem_req = 1'b0;
        step();
        check("hrd_ack_clr", 32'(t80_cpu_mem_ack), 32'd0);

        // T80 reads host-written 0x7FF
        mem_req = 1'b1; mem_rd = 1'b1; addr = 11'h7FF;
        step(); step(); step();
        check("t80x_ack",  32'(mem_ack), 32'd1);
        check("t80x_data", 32'(mem_rdata), 32'h5A);
        mem_req = 1'b0;
        step();

        // Host write to 0x800 aliases onto 0x000
        addr12 = 12'h800;
        cpu_t80_mem_req = 1'b1; cpu_t80_mem_read = 1'b0;
        cpu_t80_addr = addr12[ASZ-1:0]; cpu_t80_mem_wdata = 8'h77;
        step();
        check("alias_addr", 32'(ram_addr), 32'h000);
        step(); step();
        check("alias_ack",  32'(t80_cpu_mem_ack), 32'd1);
        cpu_t80_mem_req = 1'b0;
        step();
        mem_req = 1'b1; mem_rd = 1'b1; addr = 11'h000;
        step(); step(); step();
        check("alias_rd",   32'(mem_rdata), 32'h77);
        mem_req = 1'b0;
        step();

        // T80 write 0x3C to 0x010; read data register keeps 0x77
        mem_req = 1'b1; mem_rd = 1'b0; addr = 11'h010; mem_wdata = 8'h3C;
        step();
        check("t80wr_cs",    32'(ram_cs), 32'd1);
        check("t80wr_we",    32'(ram_we), 32'd1);
        check("t80wr_addr",  32'(ram_addr), 32'h010);
        check("t80wr_wdata", 32'(ram_wdata), 32'h3C);
        step();
        check("t80wr_we2",   32'(ram_we), 32'd0);
        step();
        check("t80wr_ack",   32'(mem_ack), 32'd1);
        check("t80wr_rdata", 32'(mem_rdata), 32'h77);
        mem_req = 1'b0;
        step();

        // Simultaneous requests from reset: T80 first, then alternate
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_req = 1'b1; mem_rd = 1'b1; addr = 11'h123;
        cpu_t80_mem_req = 1'b1; cpu_t80_mem_read = 1'b1; cpu_t80_addr = 11'h010;
        step();
        check("rr_c1_addr", 32'(ram_addr), 32'h123);
        check("rr_c1_cs",   32'(ram_cs), 32'd1);
        step(); step();
        check("rr_c3_mack", 32'(mem_ack), 32'd1);
        check("rr_c3_mrd",  32'(mem_rdata), 32'hA5);
        step();
        check("rr_c4_addr", 32'(ram_addr), 32'h010);
        check("rr_c4_cs",   32'(ram_cs), 32'd1);
        step(); step();
        check("rr_c6_hack", 32'(t80_cpu_mem_ack), 32'd1);
        check("rr_c6_hrd",  32'(t80_cpu_mem_rdata), 32'h3C);
        cpu_t80_mem_req = 1'b0;
        step();
        check("rr_c7_addr", 32'(ram_addr), 32'h123);
        check("rr_c7_cs",   32'(ram_cs), 32'd1);
        check("rr_c7_hclr", 32'(t80_cpu_mem_ack), 32'd0);
        cpu_t80_mem_req = 1'b1;
        step(); step();
        check("rr_c9_mack", 32'(mem_ack), 32'd1);
        mem_req = 1'b0;
        step();
        check("rr_c10_addr", 32'(ram_addr), 32'h010);
        check("rr_c10_cs",   32'(ram_cs), 32'd1);
        step(); step();
        check("rr_c12_hack", 32'(t80_cpu_mem_ack), 32'd1);
        cpu_t80_mem_req = 1'b0;
        step(); step();

        // Reset during ACCESS drops the access; fresh access afterwards
        mem_req = 1'b1; mem_rd = 1'b1; addr = 11'h123;
        step();
        check("mrst_cs", 32'(ram_cs), 32'd1);
        reset = 1'b1;
        step();
        check_all_zero("mrst");
        reset = 1'b0;
        step();
        check("mrst_re_cs",  32'(ram_cs), 32'd1);
        step();
        check("mrst_re_ack0", 32'(mem_ack), 32'd0);
        step();
        check("mrst_re_ack", 32'(mem_ack), 32'd1);
        check("mrst_re_rd",  32'(mem_rdata), 32'hA5);
        mem_req = 1'b0;
        step();
        check("mrst_re_ack_clr", 32'(mem_ack), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
